// File: rtl/pipeline_pkg.sv
// Shared pipeline types: data-memory request/response records and the
// dmem_responder FSM state encoding. Records are sized for the widest XLEN.
package pipeline_pkg;

  localparam int DMEM_XLEN_MAX = 64;
  localparam int DMEM_BE_MAX   = DMEM_XLEN_MAX / 8;

  typedef struct packed {
    logic                     we;
    logic [DMEM_XLEN_MAX-1:0] addr;
    logic [DMEM_BE_MAX-1:0]   be;
    logic [DMEM_XLEN_MAX-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [DMEM_XLEN_MAX-1:0] rdata;
    logic                     err;
  } dmem_rsp_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_resp_state_t;

endpackage

// File: rtl/dmem_array.sv
// Synchronous byte-enabled word RAM: byte-lane writes and a registered read
// of the addressed word on every rising edge.
module dmem_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [XLEN/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [XLEN-1:0]          wd,
  output logic [XLEN-1:0]          rd
);

  logic [XLEN-1:0] mem [DEPTH];

  // NOTE: storage has no reset; clearing a RAM would force it into flops.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < XLEN / 8; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wd[8*i +: 8];
      end
    end
    rd <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one outstanding request, LATENCY wait
// cycles, then a held response. Optional DMEM_RESPONDER_RANGE_CHECK_EN flags
// out-of-range addresses instead of wrapping them.
module dmem_responder
  import pipeline_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int MEMORY_CAPACITY = 256,
  parameter int LATENCY         = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN/8-1:0] req_be,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err
);

  localparam int NB    = XLEN / 8;
  localparam int AW    = $clog2(MEMORY_CAPACITY);
  localparam int OW    = $clog2(NB);
  localparam int IW    = AW - OW;
  localparam int DEPTH = MEMORY_CAPACITY / NB;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dmem_resp_state_t state, state_nxt;
  logic [CW-1:0]    cnt;
  dmem_req_t        req_q;
  dmem_rsp_t        rsp_q;
  logic             accept;
  logic             access;
  logic             addr_oor;
  logic             ram_we;
  logic [IW-1:0]    ram_index;
  logic [XLEN-1:0]  ram_rd;
  logic             unused_bits;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;
  assign access    = (state == WAIT) && (cnt == '0);

`ifdef DMEM_RESPONDER_RANGE_CHECK_EN
  assign addr_oor = |req_q.addr[DMEM_XLEN_MAX-1:AW];
  assign rsp_err  = rsp_q.err;
`else
  assign addr_oor = 1'b0;
  assign rsp_err  = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cnt <= CW'(LATENCY - 1);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - CW'(1);
      end
      if (access) begin
        rsp_q.err   <= addr_oor;
        rsp_q.rdata <= (req_q.we || addr_oor) ? '0 : DMEM_XLEN_MAX'(ram_rd);
      end
    end
  end

  // NOTE: request capture is pure datapath and is kept out of the reset block.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_q <= '{we:    req_we,
                 addr:  DMEM_XLEN_MAX'(req_addr),
                 be:    DMEM_BE_MAX'(req_be),
                 wdata: DMEM_XLEN_MAX'(req_wdata)};
    end
  end

  // The read port follows the incoming address while idle so the word is
  // already registered by the access edge, even with LATENCY of one.
  assign ram_index = (state == IDLE) ? req_addr[AW-1:OW] : req_q.addr[AW-1:OW];
  assign ram_we    = rst_n && access && req_q.we && !addr_oor;

  dmem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .be    (req_q.be[NB-1:0]),
    .index (ram_index),
    .wd    (req_q.wdata[XLEN-1:0]),
    .rd    (ram_rd)
  );

  assign rsp_rdata = rsp_q.rdata[XLEN-1:0];

  assign unused_bits = ^{req_q.addr, req_q.be, req_q.wdata, rsp_q, req_addr};

endmodule
